llh_sweep_sequencer: RTL and testbench



---
 rtl/llh_sweep_pkg.sv | 22 ++
 rtl/llh_sweep_sequencer_if.sv | 28 ++
 rtl/llh_sweep_table.sv | 27 ++
 rtl/llh_sweep_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_llh_sweep_sequencer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/llh_sweep_pkg.sv
// Shared types for the low-low-high sweep sequencer: controller states,
// step-counter width and the operating-point table entry.
package llh_sweep_pkg;

    localparam int STEP_W = 16;
    localparam int LLH_VW = 11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        APPLY   = 3'd1,
        RSTHOLD = 3'd2,
        SETTLE  = 3'd3,
        SAMPLE  = 3'd4,
        EMIT    = 3'd5
    } state_t;

    typedef struct packed {
        logic [LLH_VW-1:0] vref;
        logic [LLH_VW-1:0] vreg;
    } tbl_entry_t;

endpackage

// File: rtl/llh_sweep_sequencer_if.sv
// Result channel of the sweep sequencer: valid/ready handshake carrying
// point index, captured evaluator output and step count.
interface llh_sweep_sequencer_if #(
    parameter int AW = 3,
    parameter int OW = 9
);
    logic                            res_valid;
    logic                            res_ready;
    logic [AW-1:0]                   res_idx;
    logic [OW-1:0]                   res_value;
    logic [llh_sweep_pkg::STEP_W-1:0] res_steps;

    modport master (
        output res_valid,
        output res_idx,
        output res_value,
        output res_steps,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_idx,
        input  res_value,
        input  res_steps,
        output res_ready
    );
endinterface

// File: rtl/llh_sweep_table.sv
// Operating-point register file: one synchronous write port, one
// asynchronous read port. Contents survive reset on purpose.
module llh_sweep_table
    import llh_sweep_pkg::*;
#(
    parameter int NPTS = 8
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [$clog2(NPTS)-1:0] waddr,
    input  tbl_entry_t              wdata,
    input  logic [$clog2(NPTS)-1:0] raddr,
    output tbl_entry_t              rdata
);

    tbl_entry_t mem_r [NPTS];

    // table write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/llh_sweep_sequencer.sv
// Sweeps one evaluator over a programmed (VREF, VREG) table and returns one
// result per point. Optional early settle: LLH_SWEEP_EARLY_SETTLE_EN. VW must equal LLH_VW.
module llh_sweep_sequencer
    import llh_sweep_pkg::*;
#(
    parameter int NPTS         = 8,
    parameter int VW           = LLH_VW,
    parameter int OW           = 9,
    parameter int RST_CYCLES   = 4,
    parameter int SETTLE_STEPS = 1024,
    parameter int STABLE_CNT   = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cfg_we,
    input  logic [$clog2(NPTS)-1:0] cfg_addr,
    input  logic [VW-1:0]           cfg_vref,
    input  logic [VW-1:0]           cfg_vreg,
    input  logic [$clog2(NPTS):0]   cfg_npts,
    input  logic                    start,
    output logic                    busy,
    output logic [VW-1:0]           eval_vref,
    output logic [VW-1:0]           eval_vreg,
    output logic                    eval_reset,
    output logic                    eval_step,
    input  logic [OW-1:0]           eval_out,
    llh_sweep_sequencer_if.master   res,
    output logic                    done
);

    localparam int AW = $clog2(NPTS);
    localparam logic [AW:0]       NPTS_L   = (AW+1)'(NPTS);
    localparam logic [STEP_W-1:0] SETTLE_L = STEP_W'(SETTLE_STEPS);
    localparam logic [STEP_W-1:0] RST_L    = STEP_W'(RST_CYCLES);

    state_t            state_r;
    logic [AW-1:0]     idx_r;
    logic [AW:0]       npts_r;
    logic [STEP_W-1:0] step_cnt_r;
    logic [STEP_W-1:0] rst_cnt_r;
    logic              busy_r;
    logic [VW-1:0]     eval_vref_r;
    logic [VW-1:0]     eval_vreg_r;
    logic              eval_reset_r;
    logic              eval_step_r;
    logic              res_valid_r;
    logic [AW-1:0]     res_idx_r;
    logic [OW-1:0]     res_value_r;
    logic [STEP_W-1:0] res_steps_r;
    logic              done_r;

    tbl_entry_t        tbl_wdata_s;
    tbl_entry_t        tbl_rdata_s;
    logic              tbl_we_s;
    logic              start_ok_s;
    logic              last_pt_s;
    logic [STEP_W-1:0] step_nx_s;
    logic              settle_exit_s;

    assign tbl_we_s    = cfg_we & ~busy_r;
    assign tbl_wdata_s = '{vref: cfg_vref, vreg: cfg_vreg};
    assign start_ok_s  = (cfg_npts != (AW+1)'(0)) && (cfg_npts <= NPTS_L);
    assign last_pt_s   = ({1'b0, idx_r} == (npts_r - (AW+1)'(1)));
    assign step_nx_s   = step_cnt_r + 16'd1;

    llh_sweep_table #(.NPTS(NPTS)) u_table (
        .clk   (clk),
        .we    (tbl_we_s),
        .waddr (cfg_addr),
        .wdata (tbl_wdata_s),
        .raddr (idx_r),
        .rdata (tbl_rdata_s)
    );

`ifdef LLH_SWEEP_EARLY_SETTLE_EN
    logic [OW-1:0]     prev_out_r;
    logic [STEP_W-1:0] stable_cnt_r;
    logic [STEP_W-1:0] stable_nx_s;

    // stability run length; the first step has no predecessor to compare with
    always_comb begin
        stable_nx_s = 16'd0;
        if (step_cnt_r == 16'd0) begin
            stable_nx_s = 16'd0;
        end else if (eval_out == prev_out_r) begin
            stable_nx_s = stable_cnt_r + 16'd1;
        end else begin
            stable_nx_s = 16'd0;
        end
        settle_exit_s = (step_nx_s == SETTLE_L) || (stable_nx_s == STEP_W'(STABLE_CNT));
    end

    // previous-sample register and run counter, live only while settling
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_out_r   <= {OW{1'b0}};
            stable_cnt_r <= 16'd0;
        end else if (state_r == SETTLE) begin
            prev_out_r   <= eval_out;
            stable_cnt_r <= stable_nx_s;
        end else begin
            prev_out_r   <= prev_out_r;
            stable_cnt_r <= 16'd0;
        end
    end
`else
    // fixed-length settle
    always_comb begin
        settle_exit_s = (step_nx_s == SETTLE_L);
    end
`endif

    // sweep controller with registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            idx_r        <= {AW{1'b0}};
            npts_r       <= {(AW+1){1'b0}};
            step_cnt_r   <= 16'd0;
            rst_cnt_r    <= 16'd0;
            busy_r       <= 1'b0;
            eval_vref_r  <= {VW{1'b0}};
            eval_vreg_r  <= {VW{1'b0}};
            eval_reset_r <= 1'b1;
            eval_step_r  <= 1'b0;
            res_valid_r  <= 1'b0;
            res_idx_r    <= {AW{1'b0}};
            res_value_r  <= {OW{1'b0}};
            res_steps_r  <= 16'd0;
            done_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    eval_reset_r <= 1'b1;
                    eval_step_r  <= 1'b0;
                    if (start && start_ok_s) begin
                        npts_r  <= cfg_npts;
                        idx_r   <= {AW{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= APPLY;
                    end
                end
                APPLY: begin
                    eval_vref_r  <= tbl_rdata_s.vref;
                    eval_vreg_r  <= tbl_rdata_s.vreg;
                    eval_reset_r <= 1'b1;
                    rst_cnt_r    <= 16'd0;
                    state_r      <= RSTHOLD;
                end
                RSTHOLD: begin
                    if (rst_cnt_r == RST_L - 16'd1) begin
                        eval_reset_r <= 1'b0;
                        eval_step_r  <= 1'b1;
                        step_cnt_r   <= 16'd0;
                        state_r      <= SETTLE;
                    end else begin
                        rst_cnt_r <= rst_cnt_r + 16'd1;
                    end
                end
                SETTLE: begin
                    step_cnt_r <= step_nx_s;
                    if (settle_exit_s) begin
                        eval_step_r <= 1'b0;
                        state_r     <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    res_value_r <= eval_out;
                    res_idx_r   <= idx_r;
                    res_steps_r <= step_cnt_r;
                    res_valid_r <= 1'b1;
                    state_r     <= EMIT;
                end
                EMIT: begin
                    if (res.res_ready) begin
                        res_valid_r  <= 1'b0;
                        eval_reset_r <= 1'b1;
                        if (last_pt_s) begin
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            idx_r   <= idx_r + AW'(1);
                            state_r <= APPLY;
                        end
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    busy_r       <= 1'b0;
                    eval_reset_r <= 1'b1;
                    eval_step_r  <= 1'b0;
                    res_valid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = busy_r;
    assign eval_vref     = eval_vref_r;
    assign eval_vreg     = eval_vreg_r;
    assign eval_reset    = eval_reset_r;
    assign eval_step     = eval_step_r;
    assign done          = done_r;
    assign res.res_valid = res_valid_r;
    assign res.res_idx   = res_idx_r;
    assign res.res_value = res_value_r;
    assign res.res_steps = res_steps_r;

endmodule

// File: tb/tb_llh_sweep_sequencer.sv
// Directed bench for llh_sweep_sequencer (SETTLE_STEPS=8, RST_CYCLES=4); the
// evaluator is modelled as (vref+vreg) mod 512, or a per-cycle toggle.
module tb_llh_sweep_sequencer;

`ifdef LLH_SWEEP_EARLY_SETTLE_EN
    localparam int EXP_STEPS = 5;
`else
    localparam int EXP_STEPS = 8;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [10:0] cfg_vref;
    logic [10:0] cfg_vreg;
    logic [3:0]  cfg_npts;
    logic        start;
    logic        busy;
    logic [10:0] eval_vref;
    logic [10:0] eval_vreg;
    logic        eval_reset;
    logic        eval_step;
    logic [8:0]  eval_out;
    logic        done;
    logic        tog_mode = 1'b0;
    logic        tog = 1'b0;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    llh_sweep_sequencer_if #(.AW(3), .OW(9)) res_if ();

    llh_sweep_sequencer #(
        .NPTS(8), .VW(11), .OW(9), .RST_CYCLES(4), .SETTLE_STEPS(8), .STABLE_CNT(4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_vref   (cfg_vref),
        .cfg_vreg   (cfg_vreg),
        .cfg_npts   (cfg_npts),
        .start      (start),
        .busy       (busy),
        .eval_vref  (eval_vref),
        .eval_vreg  (eval_vreg),
        .eval_reset (eval_reset),
        .eval_step  (eval_step),
        .eval_out   (eval_out),
        .res        (res_if),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tog <= ~tog;

    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    assign eval_out = tog_mode ? {8'd0, tog} : 9'(eval_vref + eval_vreg);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [10:0] vr, input logic [10:0] vg);
        cfg_we = 1'b1; cfg_addr = a; cfg_vref = vr; cfg_vreg = vg;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic go(input logic [3:0] n);
        start = 1'b1; cfg_npts = n;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int c = 0;
        while (res_if.res_valid !== 1'b1 && c < 200) begin
            tick();
            c++;
        end
        chk(tag, 32'(res_if.res_valid), 32'd1);
    endtask

    initial begin
        int n_rst;
        int n_step;
        int cyc;
        int base;
        logic ok;

        reset_n = 1'b0; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_vref = 11'd0;
        cfg_vreg = 11'd0; cfg_npts = 4'd0; start = 1'b0; res_if.res_ready = 1'b1;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(res_if.res_valid), 32'd0);
        chk("rst_eval_reset", 32'(eval_reset), 32'd1);
        chk("rst_eval_step", 32'(eval_step), 32'd0);
        chk("rst_vref", 32'(eval_vref), 32'd0);
        reset_n = 1'b1;
        tick();

        // single point
        wr(3'd0, 11'd512, 11'd700);
        base = done_cnt;
        go(4'd1);
        chk("sp_busy", 32'(busy), 32'd1);
        n_rst = 0; n_step = 0; cyc = 0;
        while (res_if.res_valid !== 1'b1 && cyc < 200) begin
            if (eval_reset === 1'b1) n_rst++;
            if (eval_step === 1'b1) n_step++;
            tick();
            cyc++;
        end
        chk("sp_rst_cycles", 32'(n_rst), 32'd5);
        chk("sp_step_cycles", 32'(n_step), 32'(EXP_STEPS));
        chk("sp_latency", 32'(cyc), 32'(6 + EXP_STEPS));
        chk("sp_idx", 32'(res_if.res_idx), 32'd0);
        chk("sp_steps", 32'(res_if.res_steps), 32'(EXP_STEPS));
        chk("sp_value", 32'(res_if.res_value), 32'd188);
        chk("sp_vref", 32'(eval_vref), 32'd512);
        chk("sp_vreg", 32'(eval_vreg), 32'd700);
        tick();
        chk("sp_done", 32'(done), 32'd1);
        chk("sp_busy_end", 32'(busy), 32'd0);
        tick();
        chk("sp_done_once", 32'(done_cnt - base), 32'd1);
        chk("sp_vref_hold", 32'(eval_vref), 32'd512);

        // ignored starts
        go(4'd0);
        chk("npts0_busy", 32'(busy), 32'd0);
        go(4'd9);
        tick();
        chk("npts9_busy", 32'(busy), 32'd0);
        chk("npts9_eval_reset", 32'(eval_reset), 32'd1);

        // back-pressure, write-while-busy, start-while-busy
        wr(3'd0, 11'd100, 11'd200);
        wr(3'd1, 11'd300, 11'd50);
        wr(3'd2, 11'd1000, 11'd1000);
        res_if.res_ready = 1'b0;
        base = done_cnt;
        go(4'd3);
        wr(3'd1, 11'd7, 11'd7);
        wait_valid("bp_valid0");
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin start = 1'b1; cfg_npts = 4'd1; end
            if (i == 6) start = 1'b0;
            ok &= (res_if.res_valid === 1'b1) && (res_if.res_idx === 3'd0) &&
                  (res_if.res_value === 9'd300) && (res_if.res_steps === 16'(EXP_STEPS)) &&
                  (eval_step === 1'b0) && (eval_vref === 11'd100) && (busy === 1'b1);
            tick();
        end
        chk("bp_stable", 32'(ok), 32'd1);
        res_if.res_ready = 1'b1;
        tick();
        wait_valid("bp_valid1");
        chk("bp_idx1", 32'(res_if.res_idx), 32'd1);
        chk("bp_value1", 32'(res_if.res_value), 32'd350);
        chk("bp_vref1", 32'(eval_vref), 32'd300);
        tick();
        wait_valid("bp_valid2");
        chk("bp_idx2", 32'(res_if.res_idx), 32'd2);
        chk("bp_value2", 32'(res_if.res_value), 32'd464);
        tick();
        chk("bp_done", 32'(done), 32'd1);
        repeat (3) tick();
        chk("bp_done_once", 32'(done_cnt - base), 32'd1);
        chk("bp_idle", 32'(busy), 32'd0);

        // mid-sweep reset during SETTLE of point 1
        base = done_cnt;
        go(4'd3);
        wait_valid("mr_valid0");
        tick();
        repeat (7) tick();
        chk("mr_in_settle", 32'(eval_step), 32'd1);
        reset_n = 1'b0;
        tick();
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_eval_reset", 32'(eval_reset), 32'd1);
        chk("mr_eval_step", 32'(eval_step), 32'd0);
        chk("mr_valid", 32'(res_if.res_valid), 32'd0);
        chk("mr_vref", 32'(eval_vref), 32'd0);
        reset_n = 1'b1;
        repeat (2) tick();
        chk("mr_no_done", 32'(done_cnt - base), 32'd0);
        go(4'd1);
        wait_valid("mr_restart_valid");
        chk("mr_restart_idx", 32'(res_if.res_idx), 32'd0);
        chk("mr_restart_value", 32'(res_if.res_value), 32'd300);
        repeat (2) tick();

        // toggling evaluator output always runs the full step count
        tog_mode = 1'b1;
        go(4'd1);
        wait_valid("tog_valid");
        chk("tog_steps", 32'(res_if.res_steps), 32'd8);
        chk("tog_value", 32'(res_if.res_value[8:1]), 32'd0);
        repeat (2) tick();
        tog_mode = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
